apr_fm_parity: RTL and testbench

Fast-memory (AC block) parity tracker and checker. Consumes the six per-slice `edp_fm_parity_XXtoYY_h` bits produced by the EDP data-path slices. On every FM write it stores one odd-parity bit per halfword, indexed by block/address. On every FM read it recomputes parity from the returned data, compares it against the stored bit, and reports a sticky error with the failing address to the APR error logic.

---
 rtl/apr_fm_pkg.sv | 10 +
 rtl/apr_fm_parity_ram.sv | 31 +++
 rtl/apr_fm_parity.sv | 109 ++++++++++
 tb/tb_apr_fm_parity.sv | 134 +++++++++++++
 4 files changed

// File: rtl/apr_fm_pkg.sv
// apr_fm_pkg: shared types and helpers for the FM parity tracker
package apr_fm_pkg;
   localparam int FM_ADR_W = 7;
   localparam int FM_DEPTH = 128;
   typedef struct packed {logic vl, pl, vr, pr;} fm_par_ent_t;
   typedef enum logic [1:0] {IDLE = 2'b00, ERR = 2'b01, OVR = 2'b11} fm_err_st_t;
   function automatic logic [FM_ADR_W-1:0] fm_adr(input logic [2:0] blk, input logic [3:0] adr);
      return {blk, adr};
   endfunction
endpackage

// File: rtl/apr_fm_parity_ram.sv
// fm_par_ram: per-address valid/parity store with combinational read and per-half write
module fm_par_ram
   import apr_fm_pkg::*;
(
   input  logic                clk_apr_h,
   input  logic                reset_l,
   input  logic [FM_ADR_W-1:0] rd_adr,
   output logic [3:0]          rd_ent,
   input  logic [FM_ADR_W-1:0] wr_adr,
   input  logic                wr_l,
   input  logic                wr_r,
   input  logic                pl,
   input  logic                pr
);
   fm_par_ent_t mem [FM_DEPTH];
   assign rd_ent = mem[rd_adr];
   always_ff @(posedge clk_apr_h or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < FM_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_l) begin
            mem[wr_adr].vl <= 1'b1;
            mem[wr_adr].pl <= pl;
         end
         if (wr_r) begin
            mem[wr_adr].vr <= 1'b1;
            mem[wr_adr].pr <= pr;
         end
      end
   end
endmodule

// File: rtl/apr_fm_parity.sv
// apr_fm_parity: stores FM halfword parity on write, checks it on read, captures the first error
module apr_fm_parity
   import apr_fm_pkg::*;
#(
   parameter int ADR_W   = FM_ADR_W,
   parameter int CHK_LAT = 1
) (
   input  logic             clk_apr_h,
   input  logic             reset_l,
   input  logic             apr_fm_block_4_h,
   input  logic             apr_fm_block_2_h,
   input  logic             apr_fm_block_1_h,
   input  logic             apr_fm_adr_10_h,
   input  logic             apr_fm_adr_4_h,
   input  logic             apr_fm_adr_2_h,
   input  logic             apr_fm_adr_1_h,
   input  logic             con_fm_write_00to17_l,
   input  logic             con_fm_write_18to35_l,
   input  logic             ctl_fm_read_h,
   input  logic             edp_fm_parity_00to05_h,
   input  logic             edp_fm_parity_06to11_h,
   input  logic             edp_fm_parity_12to17_h,
   input  logic             edp_fm_parity_18to23_h,
   input  logic             edp_fm_parity_24to29_h,
   input  logic             edp_fm_parity_30to35_h,
   input  logic             con_fm_par_chk_en_h,
   input  logic             apr_fm_par_wr_bad_h,
   input  logic             apr_clr_fm_err_h,
   output logic             apr_fm_par_err_h,
   output logic             apr_fm_par_overrun_h,
   output logic [ADR_W-1:0] apr_fm_err_adr_h,
   output logic             apr_fm_err_left_h,
   output logic             apr_fm_err_right_h
);
   logic [ADR_W-1:0] adr;
   logic             wr_l, wr_r, hl, hr, err_l, err_r, any_err, first;
   logic [3:0]       rd_raw;
   fm_par_ent_t      chk_ent;
   fm_err_st_t       state, state_n;
   logic             pend     [CHK_LAT];
   logic [ADR_W-1:0] pend_adr [CHK_LAT];
   fm_par_ent_t      pend_ent [CHK_LAT];
   assign adr  = fm_adr({apr_fm_block_4_h, apr_fm_block_2_h, apr_fm_block_1_h},
                        {apr_fm_adr_10_h, apr_fm_adr_4_h, apr_fm_adr_2_h, apr_fm_adr_1_h});
   assign wr_l = ~con_fm_write_00to17_l;
   assign wr_r = ~con_fm_write_18to35_l;
   assign hl   = ~^{edp_fm_parity_00to05_h, edp_fm_parity_06to11_h, edp_fm_parity_12to17_h};
   assign hr   = ~^{edp_fm_parity_18to23_h, edp_fm_parity_24to29_h, edp_fm_parity_30to35_h};
   fm_par_ram u_ram (
      .clk_apr_h (clk_apr_h),
      .reset_l   (reset_l),
      .rd_adr    (adr),
      .rd_ent    (rd_raw),
      .wr_adr    (adr),
      .wr_l      (wr_l),
      .wr_r      (wr_r),
      .pl        (hl ^ apr_fm_par_wr_bad_h),
      .pr        (hr ^ apr_fm_par_wr_bad_h)
   );
   // Entry is sampled before this cycle's write lands, so a same-cycle read sees old contents
   always_ff @(posedge clk_apr_h or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < CHK_LAT; i++) begin
            pend[i]     <= 1'b0;
            pend_adr[i] <= '0;
            pend_ent[i] <= '0;
         end
      end else begin
         pend[0]     <= ctl_fm_read_h;
         pend_adr[0] <= adr;
         pend_ent[0] <= rd_raw;
         for (int i = 1; i < CHK_LAT; i++) begin
            pend[i]     <= pend[i-1];
            pend_adr[i] <= pend_adr[i-1];
            pend_ent[i] <= pend_ent[i-1];
         end
      end
   end
   // Slice inputs carry write data while a strobe is active, so the check is meaningless then
   assign chk_ent = pend_ent[CHK_LAT-1];
   assign err_l = pend[CHK_LAT-1] & con_fm_par_chk_en_h & ~wr_l & ~wr_r & chk_ent.vl & (hl != chk_ent.pl);
   assign err_r = pend[CHK_LAT-1] & con_fm_par_chk_en_h & ~wr_l & ~wr_r & chk_ent.vr & (hr != chk_ent.pr);
   always_ff @(posedge clk_apr_h or negedge reset_l) begin
      if (!reset_l) state <= IDLE;
      else          state <= state_n;
   end
   always_comb begin
      any_err = err_l | err_r;
      first   = any_err & ((state == IDLE) | apr_clr_fm_err_h);
      state_n = any_err ? (first ? ERR : OVR) : (apr_clr_fm_err_h ? IDLE : state);
   end
   always_ff @(posedge clk_apr_h or negedge reset_l) begin
      if (!reset_l) begin
         apr_fm_err_adr_h   <= '0;
         apr_fm_err_left_h  <= 1'b0;
         apr_fm_err_right_h <= 1'b0;
      end else if (first) begin
         apr_fm_err_adr_h   <= pend_adr[CHK_LAT-1];
         apr_fm_err_left_h  <= err_l;
         apr_fm_err_right_h <= err_r;
      end else if (apr_clr_fm_err_h) begin
         apr_fm_err_adr_h   <= '0;
         apr_fm_err_left_h  <= 1'b0;
         apr_fm_err_right_h <= 1'b0;
      end
   end
   assign apr_fm_par_err_h     = state[0];
   assign apr_fm_par_overrun_h = state[1];
endmodule

// File: tb/tb_apr_fm_parity.sv
// tb_apr_fm_parity: directed plus random checking against a halfword-level parity model
module tb_apr_fm_parity;
   logic       clk = 1'b0, reset_l = 1'b0;
   logic [6:0] a = '0;
   logic       wl_n = 1'b1, wr_n = 1'b1, rd = 1'b0, en = 1'b1, bad = 1'b0, clr = 1'b0;
   logic [35:0] d = '0;
   logic       par_err, par_ovr, err_left, err_right;
   logic [6:0] err_adr;
   int ncmp = 0, nfail = 0;

   logic m_vl [128], m_pl [128], m_vr [128], m_pr [128];
   logic m_pend, m_pvl, m_ppl, m_pvr, m_ppr;
   logic [6:0] m_pa;
   logic e_err, e_ovr, e_left, e_right;
   logic [6:0] e_adr;

   always #5 clk = ~clk;

   apr_fm_parity dut (
      .clk_apr_h(clk), .reset_l(reset_l),
      .apr_fm_block_4_h(a[6]), .apr_fm_block_2_h(a[5]), .apr_fm_block_1_h(a[4]),
      .apr_fm_adr_10_h(a[3]), .apr_fm_adr_4_h(a[2]), .apr_fm_adr_2_h(a[1]), .apr_fm_adr_1_h(a[0]),
      .con_fm_write_00to17_l(wl_n), .con_fm_write_18to35_l(wr_n), .ctl_fm_read_h(rd),
      .edp_fm_parity_00to05_h(^d[35:30]), .edp_fm_parity_06to11_h(^d[29:24]),
      .edp_fm_parity_12to17_h(^d[23:18]), .edp_fm_parity_18to23_h(^d[17:12]),
      .edp_fm_parity_24to29_h(^d[11:6]), .edp_fm_parity_30to35_h(^d[5:0]),
      .con_fm_par_chk_en_h(en), .apr_fm_par_wr_bad_h(bad), .apr_clr_fm_err_h(clr),
      .apr_fm_par_err_h(par_err), .apr_fm_par_overrun_h(par_ovr), .apr_fm_err_adr_h(err_adr),
      .apr_fm_err_left_h(err_left), .apr_fm_err_right_h(err_right)
   );

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".err"}, {6'd0, par_err}, {6'd0, e_err});
      chk({tag, ".ovr"}, {6'd0, par_ovr}, {6'd0, e_ovr});
      chk({tag, ".adr"}, err_adr, e_adr);
      chk({tag, ".left"}, {6'd0, err_left}, {6'd0, e_left});
      chk({tag, ".right"}, {6'd0, err_right}, {6'd0, e_right});
   endtask

   task automatic model_clear();
      for (int i = 0; i < 128; i++) begin
         m_vl[i] = 0; m_pl[i] = 0; m_vr[i] = 0; m_pr[i] = 0;
      end
      {m_pend, m_pvl, m_ppl, m_pvr, m_ppr, m_pa} = '0;
      {e_err, e_ovr, e_left, e_right, e_adr} = '0;
   endtask

   // One clock: drive at negedge, advance the model, check 1 time unit after the rising edge
   task automatic cyc(input string tag, input logic r, input logic w_l, input logic w_r,
                      input logic [6:0] adr, input logic [35:0] data,
                      input logic c_en, input logic c_bad, input logic c_clr);
      logic hl, hr, el, er;
      @(negedge clk);
      rd = r; wl_n = ~w_l; wr_n = ~w_r; a = adr; d = data; en = c_en; bad = c_bad; clr = c_clr;
      hl = ~^data[35:18];
      hr = ~^data[17:0];
      el = m_pend && c_en && !w_l && !w_r && m_pvl && (hl != m_ppl);
      er = m_pend && c_en && !w_l && !w_r && m_pvr && (hr != m_ppr);
      if (el || er) begin
         if (!e_err || c_clr) begin
            e_err = 1; e_ovr = 0; e_adr = m_pa; e_left = el; e_right = er;
         end else e_ovr = 1;
      end else if (c_clr) {e_err, e_ovr, e_left, e_right, e_adr} = '0;
      m_pend = r; m_pa = adr;
      m_pvl = m_vl[adr]; m_ppl = m_pl[adr]; m_pvr = m_vr[adr]; m_ppr = m_pr[adr];
      if (w_l) begin m_vl[adr] = 1; m_pl[adr] = hl ^ c_bad; end
      if (w_r) begin m_vr[adr] = 1; m_pr[adr] = hr ^ c_bad; end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   localparam logic [35:0] DG = 36'h000000001;
   localparam logic [35:0] DB = 36'h001000000;
   localparam logic [35:0] DR = 36'h000000000;

   initial begin
      model_clear();
      #12 reset_l = 1'b1;
      #1 chk_all("reset");
      cyc("w25", 0, 1, 1, 7'h25, DG, 1, 0, 0);
      cyc("r25", 1, 0, 0, 7'h25, DR, 1, 0, 0);
      cyc("c25", 0, 0, 0, 7'h00, DG, 1, 0, 0);
      cyc("o25", 0, 0, 0, 7'h00, DG, 1, 0, 0);
      cyc("w13", 0, 1, 1, 7'h13, DG, 1, 1, 0);
      cyc("r13", 1, 0, 0, 7'h13, DR, 1, 0, 0);
      cyc("c13", 0, 0, 0, 7'h00, DG, 1, 0, 0);
      cyc("clr13", 0, 0, 0, 7'h00, DR, 1, 0, 1);
      cyc("w05", 0, 1, 1, 7'h05, DG, 1, 0, 0);
      cyc("w06", 0, 1, 1, 7'h06, DG, 1, 0, 0);
      cyc("r05", 1, 0, 0, 7'h05, DR, 1, 0, 0);
      cyc("r06", 1, 0, 0, 7'h06, DB, 1, 0, 0);
      cyc("c06", 0, 0, 0, 7'h00, DB, 1, 0, 0);
      cyc("hold", 0, 0, 0, 7'h00, DR, 1, 0, 0);
      cyc("clr", 0, 0, 0, 7'h00, DR, 1, 0, 1);
      cyc("w40l", 0, 1, 0, 7'h40, DG, 1, 0, 0);
      cyc("r40", 1, 0, 0, 7'h40, DR, 1, 0, 0);
      cyc("c40", 0, 0, 0, 7'h00, DR, 1, 0, 0);
      cyc("w11", 0, 1, 1, 7'h11, DG, 1, 0, 0);
      cyc("r11a", 1, 0, 0, 7'h11, DR, 1, 0, 0);
      cyc("c11dis", 0, 0, 0, 7'h00, DB, 0, 0, 0);
      cyc("r11b", 1, 0, 0, 7'h11, DR, 1, 0, 0);
      cyc("c11wr", 0, 0, 1, 7'h33, DB, 1, 0, 0);
      cyc("sameadr", 1, 1, 1, 7'h11, DB, 1, 0, 0);
      cyc("csame", 0, 0, 0, 7'h00, DG, 1, 0, 0);
      cyc("clr2", 0, 0, 0, 7'h00, DR, 1, 0, 1);
      cyc("w22", 0, 1, 1, 7'h22, DG, 1, 1, 0);
      cyc("r22", 1, 0, 0, 7'h22, DR, 1, 0, 0);
      #2 reset_l = 1'b0;
      #2 reset_l = 1'b1;
      model_clear();
      chk_all("midrst");
      cyc("c22", 0, 0, 0, 7'h00, DG, 1, 0, 0);
      cyc("r22x", 1, 0, 0, 7'h22, DR, 1, 0, 0);
      cyc("c22x", 0, 0, 0, 7'h00, DB, 1, 0, 0);
      for (int i = 0; i < 400; i++) begin
         logic [35:0] rd_d;
         rd_d = {$urandom, $urandom};
         cyc("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             7'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 7'h48 : 7'h00), rd_d,
             $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
